// File: rtl/wb_b3_burst_master.sv
// Wishbone B3 burst master: turns a line request into a classic single cycle or an
// incrementing/wrapping registered-feedback burst, buffering write lines up front.
module wb_b3_burst_master #(
    parameter int dw        = 32,
    parameter int aw        = 32,
    parameter int max_beats = 16
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [aw-1:0] req_adr_i,
    input  logic          req_we_i,
    input  logic [4:0]    req_len_i,
    input  logic          req_wrap_i,
    input  logic [3:0]    req_sel_i,
    input  logic          wdat_valid_i,
    output logic          wdat_ready_o,
    input  logic [dw-1:0] wdat_i,
    output logic          rdat_valid_o,
    output logic [dw-1:0] rdat_o,
    output logic          done_o,
    output logic          err_o,
    output logic [aw-1:0] wbm_adr_o,
    output logic [dw-1:0] wbm_dat_o,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_we_o,
    output logic          wbm_cyc_o,
    output logic          wbm_stb_o,
    output logic [2:0]    wbm_cti_o,
    output logic [1:0]    wbm_bte_o,
    input  logic [dw-1:0] wbm_dat_i,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    input  logic          wbm_rty_i
);
    localparam int bw = $clog2(max_beats);

    // Handshakes: a transfer happens on a rising clock edge where valid and ready are both high;
    // ready never depends combinationally on valid.
    typedef enum logic [2:0] {IDLE, LOAD, BURST, RETRY, FIN} state_t;
    state_t state, state_nxt;

    logic [aw-1:0] adr_q;
    logic          we_q, wrap_q, fail_q;
    logic [4:0]    len_q, beat_q, wptr_q;
    logic [3:0]    sel_q;
    logic [dw-1:0] line_buf [max_beats];

    logic req_fire, req_bad, wdat_fire, last_beat, last_word;
    logic bus_err, bus_rty, bus_ack, in_burst;
    logic [aw-1:0] offset, wrap_mask;

    assign req_fire  = req_valid_i & req_ready_o;
    assign wdat_fire = wdat_valid_i & wdat_ready_o;
    assign req_bad   = (req_len_i == 5'd0) || (req_len_i > 5'(max_beats)) ||
                       (req_wrap_i && !(req_len_i == 5'd4 || req_len_i == 5'd8 || req_len_i == 5'd16));
    assign last_beat = (beat_q == len_q - 5'd1);
    assign last_word = (wptr_q == len_q - 5'd1);
    assign in_burst  = (state == BURST);

    // Bus response priority: err, then rty, then ack; only the ack counts a beat.
    assign bus_err = in_burst & wbm_err_i;
    assign bus_rty = in_burst & ~wbm_err_i & wbm_rty_i;
    assign bus_ack = in_burst & ~wbm_err_i & ~wbm_rty_i & wbm_ack_i;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = req_bad ? FIN : (req_we_i ? LOAD : BURST);
            LOAD:    if (wdat_fire && last_word) state_nxt = BURST;
            BURST: begin
                if (bus_err)                    state_nxt = FIN;
                else if (bus_rty)               state_nxt = RETRY;
                else if (bus_ack && last_beat)  state_nxt = FIN;
            end
            RETRY:   state_nxt = BURST;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            adr_q        <= '0;
            we_q         <= 1'b0;
            wrap_q       <= 1'b0;
            fail_q       <= 1'b0;
            len_q        <= '0;
            sel_q        <= '0;
            beat_q       <= '0;
            wptr_q       <= '0;
            rdat_valid_o <= 1'b0;
            rdat_o       <= '0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            rdat_valid_o <= bus_ack & ~we_q;
            if (bus_ack && !we_q) rdat_o <= wbm_dat_i;
            done_o <= (state == FIN);
            err_o  <= (state == FIN) & fail_q;
            if (req_fire) begin
                adr_q  <= req_adr_i & ~aw'(3);
                we_q   <= req_we_i;
                len_q  <= req_len_i;
                wrap_q <= req_wrap_i;
                sel_q  <= req_sel_i;
                fail_q <= req_bad;
                beat_q <= '0;
                wptr_q <= '0;
            end
            if (wdat_fire) wptr_q <= wptr_q + 5'd1;
            if (bus_err) fail_q <= 1'b1;
            if (bus_ack && !last_beat) beat_q <= beat_q + 5'd1;
        end
    end

    // Line storage carries no reset; it is only observed while a write burst is active.
    always_ff @(posedge wb_clk_i) begin
        if (wdat_fire) line_buf[wptr_q[bw-1:0]] <= wdat_i;
    end

    always_comb begin
        req_ready_o  = (state == IDLE);
        wdat_ready_o = (state == LOAD);
        wbm_cyc_o    = in_burst;
        wbm_stb_o    = in_burst;
        wbm_we_o     = in_burst & we_q;
        wbm_sel_o    = in_burst ? sel_q : 4'h0;
        wbm_dat_o    = (in_burst && we_q) ? line_buf[beat_q[bw-1:0]] : '0;
        offset       = aw'({beat_q, 2'b00});
        wrap_mask    = aw'({len_q, 2'b00}) - aw'(1);
        wbm_adr_o    = '0;
        wbm_cti_o    = 3'b000;
        wbm_bte_o    = 2'b00;
        if (in_burst) begin
            // Wrapping keeps the upper address bits and rolls the low bits within the line.
            if (wrap_q) wbm_adr_o = (adr_q & ~wrap_mask) | ((adr_q + offset) & wrap_mask);
            else        wbm_adr_o = adr_q + offset;
            if (len_q != 5'd1) wbm_cti_o = last_beat ? 3'b111 : 3'b010;
            if (wrap_q) begin
                case (len_q)
                    5'd4:    wbm_bte_o = 2'b01;
                    5'd8:    wbm_bte_o = 2'b10;
                    5'd16:   wbm_bte_o = 2'b11;
                    default: wbm_bte_o = 2'b00;
                endcase
            end
        end
    end
endmodule

// File: doc/wb_b3_burst_master.md
Name: wb_b3_burst_master

Overview:
- Wishbone B3 burst master that sits directly upstream of the on-chip RAM slave.
- Turns a simple line request (address, beat count, direction, wrap flag) into a classic single cycle or a registered-feedback incrementing burst (cti 010 ... 111) with linear or wrap bte.
- Buffers a whole write line before it starts the bus cycle, so stb is never dropped mid-burst.
- Streams read beats out as they are acked. Used by cache refill and DMA clients.

Parameters:
dw, 32, data width (fixed 4 bytes/word; sel is 4 bits)
aw, 32, address width
max_beats, 16, write buffer depth and maximum burst length

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  request strobe
req_ready_o  out  1  request accepted when valid&ready
req_adr_i  in  aw  start byte address; bits [1:0] ignored
req_we_i  in  1  1=write, 0=read
req_len_i  in  5  beats, 1..16
req_wrap_i  in  1  wrap burst; len must be 4, 8 or 16
req_sel_i  in  4  byte select, used for all beats
wdat_valid_i  in  1  write data valid
wdat_ready_o  out  1  write data accepted when valid&ready
wdat_i  in  dw  write data, in beat order
rdat_valid_o  out  1  one-cycle read-beat strobe; no backpressure
rdat_o  out  dw  read data
done_o  out  1  one-cycle pulse, request finished
err_o  out  1  qualifies done_o: request failed
wbm_adr_o  out  aw
wbm_dat_o  out  dw
wbm_sel_o  out  4
wbm_we_o  out  1
wbm_cyc_o  out  1
wbm_stb_o  out  1
wbm_cti_o  out  3
wbm_bte_o  out  2
wbm_dat_i  in  dw
wbm_ack_i  in  1
wbm_err_i  in  1
wbm_rty_i  in  1

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (wb_clk_i / wb_rst_i).
- Reset values:
  - All outputs 0 except req_ready_o, which is 1.
  - State IDLE; buffer pointers and beat counter 0.
  - Reset asserted mid-burst: cyc/stb drop the next edge; no done_o is produced.
- States: IDLE, LOAD, BURST, RETRY, FIN.
- IDLE:
  - req_ready_o=1. On accept, latch adr (word-aligned), we, len, wrap, sel.
  - Bad request (len 0, len>16, or wrap with len not in {4,8,16}): go to FIN with err; no bus activity.
  - Good write -> LOAD. Good read -> BURST.
- LOAD:
  - wdat_ready_o=1 until len words are stored in the buffer, then BURST next cycle.
  - wdat_ready_o=0 in all other states.
- BURST:
  - cyc=stb=1 continuously; we/sel from the latched request; wbm_dat_o = buffer[beat].
  - Read: cyc asserts the cycle after accept. Write: cyc asserts the cycle after the last word is loaded.
  - cti: len==1 -> 000. Otherwise 010 for beats 0..len-2 and 111 on the last beat.
  - bte: linear -> 00; wrap 4/8/16 -> 01/10/11.
  - On each ack, the registered adr/cti/dat advance the next cycle. Linear: adr+4. Wrap: low log2(len)+2 bits increment modulo len*4, upper bits held.
  - Read ack: rdat_o=wbm_dat_i and rdat_valid_o=1, registered, appearing the cycle after the ack.
  - Last ack: cyc/stb low next cycle -> FIN.
- Error: wbm_err_i while stb -> cyc/stb low next cycle, remaining beats discarded, FIN with err. No rdat_valid_o for the errored beat.
- Retry: wbm_rty_i -> cyc/stb low for exactly one cycle (RETRY), then re-enter BURST at the current beat. adr, beat index and cti are recomputed for the remaining beats; the restarted tail keeps 010/111.
- Simultaneous ack and err/rty: err wins, then rty, then ack; the beat is not counted.
- FIN: done_o=1 (err_o=1 if failed) for one cycle -> IDLE.
- Ack while cyc=0: ignored.
- Counters are 5-bit; beat index never exceeds len-1.

Test Plan:
- Single read, len=1, adr 0x4: cti=000, bte=00, one ack -> rdat_valid_o once with RAM word 1, then done_o=1, err_o=0.
- Linear write, len=4, adr 0x0, sel=F, data A0..A3: cyc only after 4 loads; adr 0,4,8,C; cti 010,010,010,111; read-back matches.
- Wrap read, len=8, adr 0x18: bte=10; adr 18,1C,00,04,08,0C,10,14; 8 rdat strobes in that order.
- Slave asserts err on beat 2 of a 4-beat read: 2 rdat strobes, cyc low next cycle, done_o=err_o=1.
- rty on beat 1 of a 4-beat linear write at 0x0: one idle cycle, then restart at adr 0x4 with cti 010,010,111; all 4 words land.
- Invalid request (len=5, wrap=1): no cyc; done_o=err_o=1 two cycles after accept. Separately, reset mid-burst: cyc=0 next cycle, req_ready_o=1.
